// File: rtl/im_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM states and the
// default memory geometry used by the loader, instruction memory and computer top.
package im_loader_pkg;

  localparam int IM_IW    = 15;
  localparam int IM_AW    = 6;
  localparam int IM_DEPTH = 64;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LO    = 3'd1,
    ST_HI    = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } state_e;

endpackage

// File: rtl/im_loader.sv
// Boot-time loader: takes a count byte followed by low/high byte pairs, writes the
// assembled words to instruction memory and keeps the CPU in reset until finished.
module im_loader
  import im_loader_pkg::*;
#(
  parameter int IW    = IM_IW,
  parameter int AW    = IM_AW,
  parameter int DEPTH = IM_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          im_we,
  output logic [AW-1:0] im_addr,
  output logic [IW-1:0] im_wdata,
  output logic          cpu_hold,
  output logic          done,
  output logic          err
);

  localparam logic [8:0]  DEPTH_W = 9'(DEPTH);
  localparam logic [AW:0] ONE_W   = (AW+1)'(1);

  state_e        state_q, state_d;
  logic [AW:0]   idx_q, idx_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [7:0]    lo_q, lo_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [IW-1:0] wdata_q, wdata_d;
  logic          take_byte;
  logic [AW:0]   idx_inc;

  // Ready depends only on state (and reset), never on in_valid.
  assign in_ready  = ((state_q == ST_IDLE) || (state_q == ST_LO) || (state_q == ST_HI)) && !rst;
  assign take_byte = in_valid && in_ready;
  assign idx_inc   = idx_q + ONE_W;

  assign im_we    = (state_q == ST_WRITE);
  assign im_addr  = addr_q;
  assign im_wdata = wdata_q;
  assign cpu_hold = (state_q != ST_DONE);
  assign done     = (state_q == ST_DONE);
  assign err      = (state_q == ST_ERR);

  // Next-state and datapath updates for the load sequence.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    lo_d    = lo_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (take_byte) begin
          cnt_d = (AW+1)'(in_data);
          idx_d = '0;
          if (in_data == 8'd0) begin
            state_d = ST_DONE;
          end else if ({1'b0, in_data} > DEPTH_W) begin
            state_d = ST_ERR;
          end else begin
            state_d = ST_LO;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LO: begin
        if (take_byte) begin
          lo_d    = in_data;
          state_d = ST_HI;
        end else begin
          state_d = ST_LO;
        end
      end
      ST_HI: begin
        // Address and data are captured here so they are stable during WRITE.
        if (take_byte) begin
          addr_d  = idx_q[AW-1:0];
          wdata_d = {in_data[IW-9:0], lo_q};
          state_d = ST_WRITE;
        end else begin
          state_d = ST_HI;
        end
      end
      ST_WRITE: begin
        idx_d = idx_inc;
        if (idx_inc == cnt_q) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_LO;
        end
      end
      ST_DONE: state_d = ST_DONE;
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      lo_q    <= 8'd0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      lo_q    <= lo_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

endmodule

// File: tb/tb_im_loader.sv
// Self-checking bench for im_loader: a byte-stream level model predicts every
// output cycle by cycle, and directed scenarios pin a few results by hand.
module tb_im_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_ready;
  logic        im_we;
  logic [5:0]  im_addr;
  logic [14:0] im_wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;
  int wr_count = 0;
  logic [15:0] mem_log [64];

  // model state: what the byte stream so far implies
  bit   m_have_n = 0, m_have_lo = 0, m_wr_pending = 0, m_done = 0, m_err = 0;
  int   m_n = 0, m_word = 0, m_addr = 0, m_data = 0;
  logic [7:0] m_lo = 8'd0;

  im_loader #(.IW(15), .AW(6), .DEPTH(64)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_ready();
    return !rst && !m_done && !m_err && !m_wr_pending;
  endfunction

  // Model: advance on each clock edge from the bytes the bench offered.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_have_n = 0; m_have_lo = 0; m_wr_pending = 0; m_done = 0; m_err = 0;
        m_n = 0; m_word = 0;
      end else if (m_wr_pending) begin
        m_wr_pending = 0;
        m_word++;
        if (m_word == m_n) m_done = 1;
      end else if (in_valid && !m_done && !m_err) begin
        if (!m_have_n) begin
          m_have_n = 1;
          m_n = int'(in_data);
          if (m_n == 0) m_done = 1;
          else if (m_n > 64) m_err = 1;
        end else if (!m_have_lo) begin
          m_lo = in_data;
          m_have_lo = 1;
        end else begin
          m_have_lo = 0;
          m_addr = m_word;
          m_data = (int'(in_data) % 128) * 256 + int'(m_lo);
          m_wr_pending = 1;
        end
      end
    end
  end

  // Compare: every falling edge, DUT outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_in_ready", in_ready, 0);
        chk("rst_im_we", im_we, 0);
        chk("rst_cpu_hold", cpu_hold, 1);
      end else begin
        chk("in_ready", in_ready, exp_ready());
        chk("im_we", im_we, m_wr_pending);
        if (m_wr_pending) begin
          chk("im_addr", im_addr, m_addr);
          chk("im_wdata", im_wdata, m_data);
        end
        chk("done", done, m_done);
        chk("err", err, m_err);
        chk("cpu_hold", cpu_hold, !m_done);
        if (im_we) begin
          mem_log[im_addr] = {1'b0, im_wdata};
          wr_count++;
        end
      end
    end
  end

  // Offer each byte until it is taken; t_first is the cycle the first byte transfers.
  task automatic send_bytes(input logic [7:0] q[$], input bit rnd, output int t_first);
    bit rdy;
    int c;
    t_first = -1;
    foreach (q[i]) begin
      bit taken = 0;
      for (int g = 0; g < 100 && !taken; g++) begin
        in_data  = q[i];
        in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
        rdy = in_ready;
        c = cyc;
        @(posedge clk);
        if (in_valid && rdy) begin
          taken = 1;
          if (i == 0) t_first = c;
        end
        #2;
      end
      if (!taken) chk("accept_timeout", 0, 1);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_end(output int t);
    t = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done || err) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) chk("end_timeout", 0, 1);
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    #1 rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    wr_count = 0;
  endtask

  initial begin
    logic [7:0] s[$];
    int t0, t1;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_hold_ready", in_ready, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", in_ready, 1);
    chk("reset_we", im_we, 0);
    chk("reset_addr", im_addr, 0);
    chk("reset_wdata", im_wdata, 0);
    chk("reset_hold", cpu_hold, 1);
    chk("reset_done", done, 0);
    chk("reset_err", err, 0);
    @(posedge clk);
    #2;

    // N=2, continuous valid
    s = '{8'h02, 8'h11, 8'h05, 8'h22, 8'h7F};
    send_bytes(s, 0, t0);
    wait_end(t1);
    chk("n2_done_cycle", t1 - t0, 7);
    chk("n2_writes", wr_count, 2);
    chk("n2_word0", mem_log[0], 16'h0511);
    chk("n2_word1", mem_log[1], 16'h7F22);
    chk("n2_hold", cpu_hold, 0);

    // same stream, random valid gaps
    do_reset();
    mem_log[0] = 16'hFFFF;
    mem_log[1] = 16'hFFFF;
    send_bytes(s, 1, t0);
    wait_end(t1);
    chk("rnd_writes", wr_count, 2);
    chk("rnd_word0", mem_log[0], 16'h0511);
    chk("rnd_word1", mem_log[1], 16'h7F22);

    // N=0
    do_reset();
    s = '{8'h00};
    send_bytes(s, 0, t0);
    wait_end(t1);
    chk("n0_done_cycle", t1 - t0, 1);
    chk("n0_writes", wr_count, 0);
    chk("n0_hold", cpu_hold, 0);

    // N=DEPTH+1 is rejected, later bytes ignored
    do_reset();
    s = '{8'd65};
    send_bytes(s, 0, t0);
    wait_end(t1);
    in_data  = 8'h55;
    in_valid = 1'b1;
    repeat (5) @(posedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("err_flag", err, 1);
    chk("err_hold", cpu_hold, 1);
    chk("err_ready", in_ready, 0);
    chk("err_writes", wr_count, 0);
    @(posedge clk);
    #2;

    // reset after the low byte of word 1, then reload
    do_reset();
    s = '{8'h02, 8'h11, 8'h05, 8'h22};
    send_bytes(s, 0, t0);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_ready", in_ready, 0);
    chk("mid_rst_we", im_we, 0);
    chk("mid_rst_addr", im_addr, 0);
    chk("mid_rst_wdata", im_wdata, 0);
    chk("mid_rst_hold", cpu_hold, 1);
    chk("mid_rst_done", done, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    wr_count = 0;
    s = '{8'h01, 8'hAA, 8'h01};
    send_bytes(s, 0, t0);
    wait_end(t1);
    chk("reload_writes", wr_count, 1);
    chk("reload_word0", mem_log[0], 16'h01AA);
    chk("reload_done", done, 1);

    // full 64-word load; high byte bit 7 must be dropped
    do_reset();
    s = '{8'd64};
    for (int i = 0; i < 64; i++) begin
      s.push_back(8'(i));
      s.push_back(8'h81);
    end
    send_bytes(s, 0, t0);
    wait_end(t1);
    chk("full_writes", wr_count, 64);
    chk("full_word0", mem_log[0], 16'h0100);
    chk("full_word32", mem_log[32], 16'h0120);
    chk("full_word63", mem_log[63], 16'h013F);
    chk("full_done", done, 1);
    chk("full_err", err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
